// File: rtl/usb_cmd_stream_ctrl.sv
// usb_cmd_stream_ctrl: FX2 command-frame register decoder and upstream burst gate
module usb_cmd_stream_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int BURST_WORDS = 256,
  parameter int USEDW_W = 10,
  parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
  input  logic                        clk_24m,
  input  logic                        rst,
  input  logic                        dn_val,
  input  logic [15:0]                 dn_dat,
  output logic                        up_req,
  input  logic                        up_grant,
  input  logic                        up_fin,
  output logic [15:0]                 up_dat,
  input  logic [15:0]                 fifo_q,
  input  logic [USEDW_W-1:0]          fifo_rdusedw,
  output logic                        fifo_rdreq,
  output logic [32*(NUM_REGS-1)-1:0]  reg_flat,
  output logic                        stream_en,
  output logic [7:0]                  frame_err_cnt,
  output logic [15:0]                 seq_num
);
  localparam int IW = USEDW_W + 2;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;
  state_t state_q, state_d;
  logic [1:0] wc_q, wc_d;
  logic [8:0] cmd_q, cmd_d;
  logic [15:0] dhi_q, dhi_d, dlo_q, dlo_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [7:0] err_q, err_d;
  logic [15:0] seq_q, seq_d;
  logic up_req_q, up_req_d, hdr_act_q, hdr_act_d;
  logic [IW-1:0] idx_q, idx_d, hoff, pend;
  logic [15:0] sw;
  logic frame_end, do_wr, bad, clr, payload, seq_inc;
  always_comb begin
    sw = {dn_dat[7:0], dn_dat[15:8]};
    wc_d = dn_val ? (wc_q == 2'd3 ? 2'd3 : wc_q + 2'd1) : 2'd0;
    cmd_d = (dn_val && wc_q == 2'd0) ? {sw[15], sw[7:0]} : cmd_q;
    dhi_d = (dn_val && wc_q == 2'd1) ? sw : dhi_q;
    dlo_d = (dn_val && wc_q == 2'd2) ? sw : dlo_q;
    frame_end = !dn_val && wc_q != 2'd0;
    do_wr = frame_end && wc_q == 2'd3 && cmd_q[8] && cmd_q[7:0] < 8'(NUM_REGS);
    bad = frame_end && (wc_q != 2'd3 || (cmd_q[8] && cmd_q[7:0] >= 8'(NUM_REGS)));
    clr = do_wr && cmd_q[7:0] == 8'd0 && dlo_q[2];
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++)
      if (do_wr && cmd_q[7:0] == 8'(i)) regs_d[i] = {dhi_q, dlo_q};
    regs_d[0][2] = 1'b0;
    err_d = clr ? 8'd0 : (bad && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    hoff = hdr_act_q ? IW'(2) : '0;
    pend = hoff + IW'(BURST_WORDS);
    payload = idx_q >= hoff && idx_q < pend;
    state_d = state_q;
    up_req_d = up_req_q;
    hdr_act_d = hdr_act_q;
    idx_d = idx_q;
    seq_inc = 1'b0;
    up_dat = fifo_q;
    fifo_rdreq = 1'b0;
    case (state_q)
      S_IDLE: state_d = regs_q[0][0] ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!regs_q[0][0]) state_d = S_IDLE;
        else if (fifo_rdusedw >= USEDW_W'(BURST_WORDS)) begin
          state_d = S_BURST;
          up_req_d = 1'b1;
          idx_d = '0;
          hdr_act_d = regs_q[0][1];
        end
      end
      S_BURST: begin
        up_dat = (hdr_act_q && idx_q == '0) ? SYNC_WORD :
                 (hdr_act_q && idx_q == IW'(1)) ? seq_q :
                 payload ? fifo_q : 16'h0000;
        fifo_rdreq = payload && up_grant;
        if (up_grant && idx_q < pend) idx_d = idx_q + IW'(1);
        if (up_fin) begin
          up_req_d = 1'b0;
          seq_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    seq_d = clr ? 16'd0 : seq_inc ? seq_q + 16'd1 : seq_q;
  end
  always_ff @(posedge clk_24m) begin
    if (rst) begin
      state_q <= S_IDLE;
      wc_q <= '0;
      cmd_q <= '0;
      dhi_q <= '0;
      dlo_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      err_q <= '0;
      seq_q <= '0;
      up_req_q <= 1'b0;
      hdr_act_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      wc_q <= wc_d;
      cmd_q <= cmd_d;
      dhi_q <= dhi_d;
      dlo_q <= dlo_d;
      regs_q <= regs_d;
      err_q <= err_d;
      seq_q <= seq_d;
      up_req_q <= up_req_d;
      hdr_act_q <= hdr_act_d;
      idx_q <= idx_d;
    end
  end
  for (genvar k = 1; k < NUM_REGS; k++) begin : g_flat
    assign reg_flat[32*k-1 -: 32] = regs_q[k];
  end
  assign up_req = up_req_q;
  assign stream_en = regs_q[0][0];
  assign frame_err_cnt = err_q;
  assign seq_num = seq_q;
endmodule
